// File: rtl/booth4_mult_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth4_mult_seq_pkg
// Description : Shared types and helpers for the radix-4 Booth sequential
//               multiplier: FSM states, Booth op codes, counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package booth4_mult_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } booth4_state_e;

  // Booth partial-product selections
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD1 = 3'd1,
    OP_ADD2 = 3'd2,
    OP_SUB1 = 3'd3,
    OP_SUB2 = 3'd4
  } booth4_op_e;

  // Iteration counter width; never narrower than one bit
  function automatic int booth4_cnt_w(input int iter);
    return (iter <= 1) ? 1 : $clog2(iter);
  endfunction

  // Radix-4 Booth recoding of the three low product bits {Q1, Q0, q_1}
  function automatic booth4_op_e booth4_decode(input logic [2:0] bits);
    booth4_op_e op;
    case (bits)
      3'b001, 3'b010: op = OP_ADD1;
      3'b011:         op = OP_ADD2;
      3'b100:         op = OP_SUB2;
      3'b101, 3'b110: op = OP_SUB1;
      default:        op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage : booth4_mult_seq_pkg
`default_nettype wire

// File: rtl/booth4_mult_seq_enc.sv
`default_nettype none
// ============================================================================
// Module      : booth4_enc
// Description : Combinational Booth encoder. Turns the three low product bits
//               and the guard-extended multiplicand into the signed addend.
// Revision    : 1.0 - initial release
// ============================================================================
module booth4_enc
  import booth4_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_bits,
  input  logic [WIDTH+1:0] i_m,
  output logic [WIDTH+1:0] o_addend
);

  logic [WIDTH+1:0] w_m2;
  booth4_op_e       w_op;

  // 2M cannot overflow because M already carries two sign-guard bits
  assign w_m2 = {i_m[WIDTH:0], 1'b0};
  assign w_op = booth4_decode(i_bits);

  // Select the addend; subtraction is two's complement negation mod 2^(WIDTH+2)
  always_comb begin
    o_addend = '0;
    case (w_op)
      OP_ADD1: o_addend = i_m;
      OP_ADD2: o_addend = w_m2;
      OP_SUB1: o_addend = -i_m;
      OP_SUB2: o_addend = -w_m2;
      default: o_addend = '0;
    endcase
  end

endmodule : booth4_enc
`default_nettype wire

// File: rtl/booth4_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth4_mult_seq
// Description : Multi-cycle signed multiplier, radix-4 Booth, two multiplier
//               bits retired per clock. Start/ready handshake and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module booth4_mult_seq
  import booth4_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int ITER   = WIDTH / 2;
  localparam int CNT_W  = booth4_cnt_w(ITER);
  localparam int P_W    = 2 * WIDTH + 3;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(ITER - 1);

  // P = {ACC[WIDTH+1:0], Q[WIDTH-1:0], q_1}
  booth4_state_e    r_state;
  logic [CNT_W-1:0] r_count;
  logic [P_W-1:0]   r_p;
  logic [WIDTH+1:0] r_m;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic [WIDTH+1:0] w_addend;
  logic [WIDTH+1:0] w_acc_sum;
  logic [P_W-1:0]   w_p_next;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  booth4_enc #(.WIDTH(WIDTH)) u_enc (
    .i_bits   (r_p[2:0]),
    .i_m      (r_m),
    .o_addend (w_addend)
  );

  // One Booth step: add the selected multiple, then arithmetic shift right by 2
  assign w_acc_sum = r_p[P_W-1:WIDTH+1] + w_addend;
  assign w_p_next  = {{2{w_acc_sum[WIDTH+1]}}, w_acc_sum, r_p[WIDTH:2]};
  assign w_hi_next = w_p_next[2*WIDTH:WIDTH+1];
  assign w_lo_next = w_p_next[WIDTH:1];

  // Sequencer: load, iterate, publish result with a one-cycle ready pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_exc   <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_p     <= w_p_next;
          r_count <= r_count + 1'b1;
          if (r_count == c_last) begin
            r_lo    <= w_lo_next;
            r_hi    <= w_hi_next;
            r_exc   <= (w_hi_next != {WIDTH{w_lo_next[WIDTH-1]}});
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start (back-to-back issue)
          r_rdy <= 1'b0;
          if (ctrl_mult) begin
            r_p     <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
            r_m     <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign data_result    = r_lo;
  assign data_result_hi = r_hi;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule : booth4_mult_seq
`default_nettype wire

// File: tb/tb_booth4_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth4_mult_seq
// Description : Directed self-checking bench for booth4_mult_seq (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth4_mult_seq;

  localparam int WIDTH = 32;
  localparam int LAT   = 16;   // negedges from start edge to first RDY sample
  localparam int LIMIT = 40;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ctrl_mult = 1'b0;
  logic [WIDTH-1:0] data_operandA = '0;
  logic [WIDTH-1:0] data_operandB = '0;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_result_hi;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  int checks = 0;
  int errors = 0;

  booth4_mult_seq #(.WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_result_hi (data_result_hi),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start for exactly one rising edge; returns at the negedge after it
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_mult     = 1'b1;
    @(negedge clock);
    ctrl_mult     = 1'b0;
  endtask

  // Count negedges until RDY; reports whether busy dropped early
  task automatic wait_rdy(output int n, output bit busy_gap);
    n = 0;
    busy_gap = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      if (data_resultRDY) break;
      @(negedge clock);
      n++;
      if (!data_resultRDY && !busy) busy_gap = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] lo,
                              input logic [WIDTH-1:0] hi, input logic exc);
    chk({tag, "_lo"},  64'(data_result), 64'(lo));
    chk({tag, "_hi"},  64'(data_result_hi), 64'(hi));
    chk({tag, "_exc"}, 64'(data_exception), 64'(exc));
    chk({tag, "_busy_at_rdy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int  n;
    bit  gap;
    bit  extra_rdy;
    bit  busy_low;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_lo",   64'(data_result), 64'd0);
    chk("rst_hi",   64'(data_result_hi), 64'd0);
    chk("rst_exc",  64'(data_exception), 64'd0);
    chk("rst_rdy",  64'(data_resultRDY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // 3 * -4 = -12
    start_op(32'd3, 32'hFFFFFFFC);
    chk("v1_busy", 64'(busy), 64'd1);
    wait_rdy(n, gap);
    chk("v1_latency", 64'(n), 64'(LAT));
    chk("v1_busy_gap", 64'(gap), 64'd0);
    check_result("v1", 32'hFFFFFFF4, 32'hFFFFFFFF, 1'b0);
    @(negedge clock);
    chk("v1_rdy_pulse", 64'(data_resultRDY), 64'd0);

    // 0x7FFFFFFF * 2 overflows the low word
    start_op(32'h7FFFFFFF, 32'd2);
    wait_rdy(n, gap);
    chk("v2_latency", 64'(n), 64'(LAT));
    check_result("v2", 32'hFFFFFFFE, 32'h00000000, 1'b1);

    // (-2^31)^2 = 2^62: -2M path and guard bits
    start_op(32'h80000000, 32'h80000000);
    wait_rdy(n, gap);
    chk("v3_latency", 64'(n), 64'(LAT));
    check_result("v3", 32'h00000000, 32'h40000000, 1'b1);

    // 7 * 6 with a second start at cycle 5 that must be ignored
    start_op(32'd7, 32'd6);
    repeat (4) @(negedge clock);
    chk("v4_hold_lo", 64'(data_result), 64'h00000000);
    chk("v4_hold_hi", 64'(data_result_hi), 64'h40000000);
    data_operandA = 32'd1;
    data_operandB = 32'd1;
    ctrl_mult     = 1'b1;
    @(negedge clock);
    ctrl_mult     = 1'b0;
    chk("v4_busy_after_restart", 64'(busy), 64'd1);
    wait_rdy(n, gap);
    chk("v4_latency", 64'(n + 5), 64'(LAT));
    chk("v4_busy_gap", 64'(gap), 64'd0);
    check_result("v4", 32'd42, 32'd0, 1'b0);
    extra_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (data_resultRDY) extra_rdy = 1'b1;
    end
    chk("v4_single_rdy", 64'(extra_rdy), 64'd0);

    // 5 * 5 aborted by reset at cycle 8
    start_op(32'd5, 32'd5);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("v5_rst_lo",   64'(data_result), 64'd0);
    chk("v5_rst_hi",   64'(data_result_hi), 64'd0);
    chk("v5_rst_exc",  64'(data_exception), 64'd0);
    chk("v5_rst_busy", 64'(busy), 64'd0);
    extra_rdy = 1'b0;
    busy_low  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (data_resultRDY) extra_rdy = 1'b1;
      if (busy) busy_low = 1'b0;
    end
    chk("v5_no_rdy", 64'(extra_rdy), 64'd0);
    chk("v5_idle", 64'(busy_low), 64'd1);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_rdy(n, gap);
    chk("v5b_latency", 64'(n), 64'(LAT));
    check_result("v5b", 32'd1, 32'd0, 1'b0);

    // Back-to-back: 2*3, then -2*3 issued in the DONE cycle
    start_op(32'd2, 32'd3);
    wait_rdy(n, gap);
    chk("v6a_latency", 64'(n), 64'(LAT));
    check_result("v6a", 32'd6, 32'd0, 1'b0);
    data_operandA = 32'hFFFFFFFE;
    data_operandB = 32'd3;
    ctrl_mult     = 1'b1;
    @(negedge clock);
    ctrl_mult     = 1'b0;
    chk("v6_rdy_drop", 64'(data_resultRDY), 64'd0);
    chk("v6_busy", 64'(busy), 64'd1);
    wait_rdy(n, gap);
    chk("v6b_latency", 64'(n), 64'(LAT));
    check_result("v6b", 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0);
    @(negedge clock);
    chk("v6b_rdy_pulse", 64'(data_resultRDY), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_booth4_mult_seq
`default_nettype wire
